// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin sharing of one interval up-counter among NUM_REQ requesters
module counter_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*CNT_W-1:0] Len,
    output logic [NUM_REQ-1:0]       Grant,
    output logic [NUM_REQ-1:0]       Done,
    output logic [CNT_W-1:0]         Count,
    output logic                     Busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_len;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_own;
    logic               w_any;
    logic [IW-1:0]      w_win;
    logic [IW:0]        w_sum;
    logic [IW-1:0]      w_idx;
    logic [CNT_W-1:0]   w_len;
    logic [IW-1:0]      w_next_ptr;

    // Scan downward so the candidate closest to the pointer is written last and wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_sum = '0;
        w_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            w_idx = IW'(w_sum >= (IW+1)'(NUM_REQ) ? w_sum - (IW+1)'(NUM_REQ) : w_sum);
            if (Req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_len      = Len[int'(w_win)*CNT_W +: CNT_W];
    assign w_next_ptr = (r_own == IW'(NUM_REQ - 1)) ? '0 : r_own + 1'b1;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_count <= '0;
            r_len   <= '0;
            r_ptr   <= '0;
            r_own   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_state <= COUNT;
                    r_grant <= NUM_REQ'(1) << w_win;
                    r_own   <= w_win;
                    r_len   <= w_len;
                    r_count <= '0;
                end
                COUNT: if (!Req[r_own]) begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_count <= '0;
                    r_ptr   <= w_next_ptr;
                end else if (r_count == r_len) begin
                    r_state <= DONE;
                    r_done  <= r_grant;
                end else begin
                    r_count <= r_count + 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_done  <= '0;
                    r_count <= '0;
                    r_ptr   <= w_next_ptr;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Grant = r_grant;
    assign Done  = r_done;
    assign Count = r_count;
    assign Busy  = (r_state != IDLE);
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: scoreboard bench; per-cycle expected outputs are queued with each stimulus
module tb_counter_scheduler;
    localparam int N = 4;
    localparam int W = 4;

    logic           Clk = 1'b0;
    logic           Reset = 1'b0;
    logic [N-1:0]   Req = '0;
    logic [N*W-1:0] Len = '0;
    logic [N-1:0]   Grant;
    logic [N-1:0]   Done;
    logic [W-1:0]   Count;
    logic           Busy;

    typedef struct packed {
        logic [N-1:0] g;
        logic [N-1:0] d;
        logic [W-1:0] c;
        logic         b;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    counter_scheduler #(.NUM_REQ(N), .CNT_W(W)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Len(Len),
        .Grant(Grant), .Done(Done), .Count(Count), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic push(input logic [N-1:0] g, input logic [N-1:0] d, input logic [W-1:0] c, input logic b);
        exp_t e;
        e.g = g;
        e.d = d;
        e.c = c;
        e.b = b;
        exp_q.push_back(e);
    endtask

    // Full grant: Len+1 counting cycles, one done cycle, one idle cycle.
    task automatic push_grant(input int own, input int len);
        logic [N-1:0] oh;
        oh = N'(1) << own;
        for (int k = 0; k <= len; k++) push(oh, '0, W'(k), 1'b1);
        push(oh, oh, W'(len), 1'b1);
        push('0, '0, '0, 1'b0);
    endtask

    task automatic step();
        exp_t e;
        @(posedge Clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("grant", 32'(Grant), 32'(e.g));
            check("done", 32'(Done), 32'(e.d));
            check("count", 32'(Count), 32'(e.c));
            check("busy", 32'(Busy), 32'(e.b));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        while (exp_q.size() > 0) step();
    endtask

    task automatic set_len(input int i, input int v);
        Len[i*W +: W] = W'(v);
    endtask

    initial begin
        // reset with all requests pending, then requester 0 wins first
        Reset = 1'b0;
        Req = 4'b1111;
        push('0, '0, '0, 1'b0);
        push('0, '0, '0, 1'b0);
        run(2);
        Reset = 1'b1;
        for (int i = 0; i < N; i++) set_len(i, 1);
        push_grant(0, 1);
        step();
        Req = 4'b0001;
        drain();
        Req = '0;

        // single requester, length 5
        set_len(2, 5);
        Req = 4'b0100;
        push_grant(2, 5);
        drain();
        Req = '0;

        // all requesters, length 2, fresh pointer
        Reset = 1'b0;
        push('0, '0, '0, 1'b0);
        step();
        Reset = 1'b1;
        for (int i = 0; i < N; i++) set_len(i, 2);
        Req = 4'b1111;
        push_grant(0, 2);
        push_grant(1, 2);
        push_grant(2, 2);
        push_grant(3, 2);
        push_grant(0, 2);
        drain();
        Req = '0;

        // length 0 and maximum length; a late Len change must be ignored
        set_len(1, 0);
        Req = 4'b0010;
        push_grant(1, 0);
        drain();
        Req = '0;
        set_len(2, 15);
        Req = 4'b0100;
        push_grant(2, 15);
        step();
        set_len(2, 3);
        drain();
        Req = '0;

        // abort by owner 1 at count 3, pending requester 2 served next
        set_len(1, 10);
        set_len(2, 1);
        Req = 4'b0110;
        for (int k = 0; k < 4; k++) push(4'b0010, '0, W'(k), 1'b1);
        push('0, '0, '0, 1'b0);
        push_grant(2, 1);
        run(4);
        Req = 4'b0100;
        drain();
        Req = '0;

        // reset in the middle of an interval at count 7
        set_len(0, 12);
        Req = 4'b0001;
        for (int k = 0; k < 8; k++) push(4'b0001, '0, W'(k), 1'b1);
        run(8);
        Reset = 1'b0;
        Req = 4'b1000;
        set_len(3, 2);
        push('0, '0, '0, 1'b0);
        step();
        Reset = 1'b1;
        push_grant(3, 2);
        drain();
        Req = '0;
        for (int i = 0; i < 3; i++) push('0, '0, '0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
